// File: rtl/uart_tx_serializer_pkg.sv
// Shared definitions for the UART transmit serializer.
// Contents:
//   uart_state_e        3-bit FSM state encoding.
//   DEFAULT_*           default bit timing and frame width.
//   calc_parity         reduction-XOR parity over the low nbits of a byte.
package uart_tx_serializer_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DEFAULT_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } uart_state_e;

  // The parity bit makes the total number of ones in the data bits plus the
  // parity bit even when odd = 0, and odd when odd = 1.
  function automatic logic calc_parity(input logic [7:0] data,
                                       input int         nbits,
                                       input logic       odd);
    logic p;
    p = odd;
    for (int i = 0; i < 8; i++) begin
      if (i < nbits) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_baud_gen.sv
// Baud counter for the UART transmit serializer.
// Counts 0..CLKS_PER_BIT-1 continuously. The counter goes back to 0 after its
// last count, or at once when restart is high.
// Ports:
//   clk          system clock, rising edge
//   areset       asynchronous active-high reset, clears the counter
//   restart      when high, the counter is 0 in the next cycle
//   bit_end      high on the last clk of a serial bit (count == CLKS_PER_BIT-1)
//   bit_pre_end  high on the clk before the last clk (count == CLKS_PER_BIT-2)
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic areset,
  input  logic restart,
  output logic bit_end,
  output logic bit_pre_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      cnt <= '0;
    end else if (restart || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Both outputs are decoded from the count register, so no input reaches
  // them through combinational logic. bit_pre_end gives the FSM one cycle of
  // warning, so it can register frame_done for the final clk of the frame.
  assign bit_end     = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign bit_pre_end = (cnt == CNT_W'(CLKS_PER_BIT - 2));

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer. It pops bytes from the transmit FIFO and sends each
// byte on tx as one frame: a start bit, the data bits LSB first, an optional
// parity bit, then the stop bits.
// Ports:
//   clk         system clock, rising edge
//   areset      asynchronous active-high reset
//   tx_en       1 = the serializer may start new frames
//   fifo_empty  the FIFO holds no data
//   fifo_data   FIFO read data, valid in the cycle after fifo_rd_en
//   fifo_rd_en  one-cycle pop strobe to the FIFO
//   tx          serial line, high when idle
//   busy        high from the pop cycle until the end of the last stop bit
//   frame_done  one-cycle pulse on the final clk of the last stop bit
//   state       current FSM state, for debug and status
//
// FIFO handshake: fifo_rd_en is a pop request. It is high for exactly one
// cycle (FETCH), and only when fifo_empty was low in the cycle that decided to
// pop. The FIFO presents the popped byte on fifo_data in the next cycle
// (LOAD), and the serializer captures the byte at the end of that cycle.
// There is at most one pop per frame, and there is no back-pressure in either
// direction.
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        tx_en,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output uart_state_e state
);

  localparam int BIT_CNT_W = $clog2(DATA_BITS + 1);

  logic [DATA_BITS-1:0] shift_reg;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 stop_cnt;
  logic                 parity_bit;
  logic                 bit_end;
  logic                 bit_pre_end;
  logic                 last_stop;
  logic                 can_start;

  // The baud counter restarts in LOAD, so the start bit is always full width
  // no matter how long the line was idle.
  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk         (clk),
    .areset      (areset),
    .restart     (state == ST_LOAD),
    .bit_end     (bit_end),
    .bit_pre_end (bit_pre_end)
  );

  assign last_stop = (STOP_BITS == 1) || stop_cnt;
  assign can_start = tx_en && !fifo_empty;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state      <= ST_IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      fifo_rd_en <= 1'b0;
      frame_done <= 1'b0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      parity_bit <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (can_start) begin
            state      <= ST_FETCH;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end

        ST_FETCH: begin
          state <= ST_LOAD;
        end

        ST_LOAD: begin
          shift_reg  <= fifo_data[DATA_BITS-1:0];
          parity_bit <= calc_parity(fifo_data, DATA_BITS, 1'(PARITY_ODD));
          bit_cnt    <= '0;
          stop_cnt   <= 1'b0;
          tx         <= 1'b0;
          state      <= ST_START;
        end

        ST_START: begin
          if (bit_end) begin
            tx    <= shift_reg[0];
            state <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                tx    <= parity_bit;
                state <= ST_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= ST_STOP;
              end
            end else begin
              // shift_reg[1] is the next bit on the line once the shift is done.
              shift_reg <= shift_reg >> 1;
              bit_cnt   <= bit_cnt + 1'b1;
              tx        <= shift_reg[1];
            end
          end
        end

        ST_PARITY: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= ST_STOP;
          end
        end

        ST_STOP: begin
          tx <= 1'b1;
          if (bit_pre_end && last_stop) frame_done <= 1'b1;
          if (bit_end) begin
            if (last_stop) begin
              stop_cnt <= 1'b0;
              if (can_start) begin
                state      <= ST_FETCH;
                fifo_rd_en <= 1'b1;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
